led_stretch: RTL and testbench
==============================

LED_STRETCH -- requirements
Module: led_stretch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 160000, clocks per stretch tick (1 ms at 160 MHz), range 2..2^20.
REQ-002 SHALL have parameter STRETCH_TICKS, default 50, ticks an LED stays lit after its input falls, range 1..255.
REQ-003 SHALL have port clock, input, 1 bit: single clock, the fixed 160 MHz PLL clock; the block uses no other clock.
REQ-004 SHALL have port res, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port cog_led, input, 8 bits: per-cog activity levels, asynchronous to clock (they come from the cog clock domain).
REQ-006 SHALL have port bright, input, 8 bits: global brightness; 0 means off, 255 means fully on.
REQ-007 SHALL have port led_n, output, 8 bits: LED drive, active low, registered.

Function
REQ-008 Each cog_led bit SHALL pass through a 2-flop synchronizer before any use.
REQ-009 A shared prescaler SHALL count from 0 to TICK_DIV-1 and wrap to 0.
REQ-010 The prescaler SHALL assert a 1-clock tick in the cycle where its count equals TICK_DIV-1.
REQ-011 An 8-bit PWM counter SHALL increment every clock and wrap from 255 to 0.
REQ-012 Each channel SHALL have an 8-bit stretch counter.
REQ-013 While the synchronized input is 1, the stretch counter SHALL load STRETCH_TICKS every cycle, regardless of tick.
REQ-014 While the synchronized input is 0 and tick=1 and the counter is non-zero, the counter SHALL decrement by 1.
REQ-015 The stretch counter SHALL saturate at 0 and never wrap.
REQ-016 Channel active SHALL equal (synchronized input = 1) OR (stretch counter != 0).
REQ-017 Channel visible SHALL equal active AND ((bright = 255) OR (pwm < bright)).
REQ-018 The pwm < bright comparison SHALL be unsigned, 8 bits wide.
REQ-019 led_n[i] SHALL be registered as NOT visible.
REQ-020 Latency SHALL be 3 clocks from cog_led[i] rising, measured at the synchronizer input, to led_n[i] falling, with bright=255.
REQ-021 After the synchronized input falls, led_n[i] SHALL stay 0 (at bright=255) for more than (STRETCH_TICKS-1)*TICK_DIV clocks and at most STRETCH_TICKS*TICK_DIV+1 clocks.
REQ-022 A rise of the input during the stretch SHALL reload the counter to STRETCH_TICKS; the stretch time restarts.
REQ-023 An input high pulse shorter than 2 clocks MAY be missed; any pulse of 2 or more clocks SHALL produce the full stretch.
REQ-024 Input fall coinciding with tick SHALL NOT decrement in that cycle, because the counter loads while the synchronized input is still 1.
REQ-025 bright=0 SHALL keep led_n=8'hFF continuously, whatever the inputs.
REQ-026 Changes to bright SHALL take effect on the next clock, with no retiming to the PWM period.
REQ-027 All 8 channels SHALL be independent and share only the prescaler, PWM counter and bright.

Reset
REQ-028 On res=1, the synchronizers, stretch counters, prescaler and PWM counter SHALL clear to 0 immediately.
REQ-029 On res=1, led_n SHALL go to 8'hFF immediately.
REQ-030 A reset asserted mid-stretch SHALL abort the stretch; after release, no LED lights until its synchronized input is 1.
REQ-031 After res deasserts, the first tick SHALL occur TICK_DIV clocks later.

Structure
REQ-032 Shared package led_pkg SHALL hold NUM_LEDS=8, PWM_W=8, CNT_W=8, and the typedef led_vec_t (logic [NUM_LEDS-1:0]).
REQ-033 One sub-module, led_stretch_chan, SHALL contain the per-channel synchronizer, stretch counter and output flop.
REQ-034 led_stretch_chan SHALL take tick, pwm and bright as inputs and be instantiated NUM_LEDS times by generate.
REQ-035 The prescaler and PWM counter SHALL live in led_stretch.

Verification (bench uses TICK_DIV=4, STRETCH_TICKS=3)
REQ-036 Reset check: res pulse mid-run -> led_n=8'hFF within the same cycle; all counters read 0.
REQ-037 Latency: bright=255, cog_led[0] rises -> led_n[0]=0 exactly 3 clocks later.
REQ-038 Stretch length: cog_led[0] high 10 clocks, then falls -> led_n[0] stays 0 for more than 8 and at most 13 clocks after the synchronized fall, then returns to 1.
REQ-039 Retrigger: cog_led[3] high 2 clocks, low 6 clocks, high 2 clocks -> led_n[3] continuous 0, stretch restarts from the second pulse.
REQ-040 PWM: bright=64, cog_led[5] held high -> led_n[5] is 0 for exactly 64 of every 256 clocks.
REQ-041 PWM limits: bright=0 -> led_n[5] stays 1; bright=255 -> led_n[5] stays 0.
REQ-042 Independence: cog_led=8'hA5 pulses -> only led_n bits 0, 2, 5, 7 fall; bits 1, 3, 4, 6 stay 1.

Source files
------------

// File: rtl/led_pkg.sv
// Shared sizes, types and the PWM gate used by the LED stretcher block.
package led_pkg;

    localparam int NUM_LEDS = 8;
    localparam int PWM_W    = 8;
    localparam int CNT_W    = 8;

    typedef logic [NUM_LEDS-1:0] led_vec_t;

    // Full brightness bypasses the compare so 255 gives a solid, flicker-free on.
    function automatic logic pwm_on(input logic [PWM_W-1:0] pwm,
                                    input logic [PWM_W-1:0] bright);
        return (bright == {PWM_W{1'b1}}) || (pwm < bright);
    endfunction

endpackage

// File: rtl/led_stretch_chan.sv
// One LED channel: input synchronizer, tick-based stretch counter and registered active-low drive.
module led_stretch_chan
    import led_pkg::*;
#(
    parameter int STRETCH_TICKS = 50
) (
    input  logic             clock,
    input  logic             res,
    input  logic             led_i,
    input  logic             tick_i,
    input  logic [PWM_W-1:0] pwm_i,
    input  logic [PWM_W-1:0] bright_i,
    output logic             led_n_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             led_n_q;
    logic             active;
    logic             visible;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (sync2_q) begin
            cnt_d = CNT_W'(STRETCH_TICKS);
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign active  = sync2_q || (cnt_q != '0);
    assign visible = active && pwm_on(pwm_i, bright_i);

    always_ff @(posedge clock or posedge res) begin
        // NOTE: non-blocking assignments keep the synchronizer a true two-stage shift.
        if (res) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            led_n_q <= 1'b1;
        end else begin
            sync1_q <= led_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            led_n_q <= ~visible;
        end
    end

    assign led_n_o = led_n_q;

endmodule

// File: rtl/led_stretch.sv
// Activity-LED stretcher: shared prescaler and PWM counter driving NUM_LEDS independent channels.
module led_stretch
    import led_pkg::*;
#(
    parameter int TICK_DIV      = 160000,
    parameter int STRETCH_TICKS = 50
) (
    input  logic                clock,
    input  logic                res,
    input  logic [NUM_LEDS-1:0] cog_led,
    input  logic [PWM_W-1:0]    bright,
    output logic [NUM_LEDS-1:0] led_n
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [PWM_W-1:0] pwm_q;
    logic             tick;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            presc_q <= '0;
            pwm_q   <= '0;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_q + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_stretch_chan #(
            .STRETCH_TICKS(STRETCH_TICKS)
        ) u_chan (
            .clock   (clock),
            .res     (res),
            .led_i   (cog_led[i]),
            .tick_i  (tick),
            .pwm_i   (pwm_q),
            .bright_i(bright),
            .led_n_o (led_n[i])
        );
    end

endmodule

// File: tb/tb_led_stretch.sv
// Directed and random checks of led_stretch against a tick-counting reference model.
module tb_led_stretch;
    import led_pkg::*;

    localparam int TD = 4;
    localparam int ST = 3;

    logic     clock = 1'b0;
    logic     res;
    led_vec_t cog_led;
    logic [7:0] bright;
    led_vec_t led_n;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycle index since reset, input delayed two edges,
    // and the last cycle in which each synchronized input was seen high.
    int       k;
    led_vec_t h1, h2;
    int       last_high [NUM_LEDS];
    led_vec_t model_led;

    led_stretch #(.TICK_DIV(TD), .STRETCH_TICKS(ST)) dut (
        .clock  (clock),
        .res    (res),
        .cog_led(cog_led),
        .bright (bright),
        .led_n  (led_n)
    );

    always #5 clock = ~clock;

    // Number of tick cycles (index mod TD == TD-1) in the inclusive range [a, b].
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / TD - a / TD;
    endfunction

    initial begin
        forever begin
            @(posedge clock or posedge res);
            if (res) begin
                k  = 0;
                h1 = '0;
                h2 = '0;
                for (int i = 0; i < NUM_LEDS; i++) last_high[i] = -1;
                model_led = '1;
            end else begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    bit act;
                    act = h2[i] || (last_high[i] >= 0 && ticks_in(last_high[i] + 1, k - 1) < ST);
                    model_led[i] = !(act && (bright == 8'd255 || (k % 256) < int'(bright)));
                    if (h2[i]) last_high[i] = k;
                end
                h2 = h1;
                h1 = cog_led;
                k++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        @(negedge clock);
        check(tag, 32'(led_n), 32'(model_led));
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    // Count edges after the synchronized fall of channel b until its LED goes dark.
    task automatic measure_stretch(input int b, output int n);
        n = 0;
        do begin
            step("stretch_model");
            n++;
        end while (led_n[b] !== 1'b1 && n < 40);
    endtask

    task automatic step_track(input int b, inout bit seen0, inout bit glitch);
        step("retrig_model");
        if (led_n[b] === 1'b0) seen0 = 1'b1;
        else if (seen0) glitch = 1'b1;
    endtask

    task automatic count_dark(input int b, output int zeros);
        zeros = 0;
        for (int i = 0; i < 256; i++) begin
            step("pwm_model");
            if (led_n[b] === 1'b0) zeros++;
        end
    endtask

    initial begin
        int  n;
        int  zeros;
        bit  seen0;
        bit  glitch;
        res     = 1'b1;
        cog_led = '0;
        bright  = 8'd255;

        repeat (2) @(negedge clock);
        check("reset_led_n", 32'(led_n), 32'hFF);
        check("reset_presc", 32'(dut.presc_q), 0);
        check("reset_pwm", 32'(dut.pwm_q), 0);
        res = 1'b0;

        // First tick lands in cycle TD-1 after release.
        steps(2, "idle");
        check("tick_early", 32'(dut.tick), 0);
        step("idle");
        check("tick_first", 32'(dut.tick), 1);
        steps(20, "idle");

        // Latency from input rise to LED on.
        cog_led[0] = 1'b1;
        n = 0;
        do begin
            step("latency_model");
            n++;
        end while (led_n[0] !== 1'b0 && n < 10);
        check("latency", n, 3);
        steps(10 - n, "hold");
        cog_led[0] = 1'b0;
        steps(2, "sync_fall");
        measure_stretch(0, n);
        check("stretch_len_in_range", 32'(n > 8 && n <= 13), 1);
        steps(20, "idle");

        // Retrigger during stretch keeps the LED solid and restarts the stretch.
        seen0  = 1'b0;
        glitch = 1'b0;
        cog_led[3] = 1'b1;
        repeat (2) step_track(3, seen0, glitch);
        cog_led[3] = 1'b0;
        repeat (6) step_track(3, seen0, glitch);
        cog_led[3] = 1'b1;
        repeat (2) step_track(3, seen0, glitch);
        cog_led[3] = 1'b0;
        repeat (2) step_track(3, seen0, glitch);
        check("retrig_lit", 32'(seen0), 1);
        check("retrig_no_gap", 32'(glitch), 0);
        measure_stretch(3, n);
        check("retrig_stretch_len", 32'(n > 8 && n <= 13), 1);
        steps(20, "idle");

        // PWM duty and the two brightness limits.
        bright     = 8'd64;
        cog_led[5] = 1'b1;
        steps(4, "pwm_settle");
        count_dark(5, zeros);
        check("pwm_64", zeros, 64);
        bright = 8'd0;
        steps(2, "pwm_settle");
        count_dark(5, zeros);
        check("pwm_off", zeros, 0);
        check("pwm_off_all", 32'(led_n), 32'hFF);
        bright = 8'd255;
        steps(2, "pwm_settle");
        count_dark(5, zeros);
        check("pwm_full", zeros, 256);
        cog_led = '0;
        steps(30, "idle");
        check("idle_dark", 32'(led_n), 32'hFF);

        // Independent channels.
        cog_led = 8'hA5;
        steps(3, "indep_model");
        check("indep_pattern", 32'(led_n), 32'h5A);
        cog_led = '0;
        steps(30, "idle");

        // Reset in the middle of a stretch.
        cog_led = 8'hFF;
        steps(5, "pre_reset");
        check("pre_reset_lit", 32'(led_n), 32'h00);
        #1 res = 1'b1;
        #1;
        check("midrun_reset_led_n", 32'(led_n), 32'hFF);
        check("midrun_reset_presc", 32'(dut.presc_q), 0);
        check("midrun_reset_pwm", 32'(dut.pwm_q), 0);
        cog_led = '0;
        @(negedge clock);
        @(negedge clock);
        res = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step("post_reset_model");
            check("post_reset_dark", 32'(led_n), 32'hFF);
        end

        // Random activity and brightness against the model.
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                case ($urandom_range(0, 5))
                    0: bright = 8'd0;
                    1: bright = 8'd1;
                    2: bright = 8'd255;
                    3: bright = 8'd254;
                    default: bright = 8'($urandom_range(0, 255));
                endcase
            end
            for (int b = 0; b < NUM_LEDS; b++)
                if ($urandom_range(0, 9) == 0) cog_led[b] = ~cog_led[b];
            step("random_model");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
